// File: rtl/branch_resolution_unit_if.sv
// Execute-stage branch resolution bus: decode-side prediction in, redirect/predictor-update/counters out.
interface branch_resolution_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
);
    logic                  stall_e;
    logic                  d_valid;
    logic [DATA_WIDTH-1:0] d_pc;
    logic [DATA_WIDTH-1:0] d_instr;
    logic                  d_pred_taken;
    logic [DATA_WIDTH-1:0] d_pred_target;
    logic                  e_branch_cond;
    logic [DATA_WIDTH-1:0] e_rs1;
    logic                  mispredict;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  upd_valid;
    logic [DATA_WIDTH-1:0] upd_pc;
    logic                  upd_taken;
    logic [DATA_WIDTH-1:0] upd_target;
    logic                  upd_uncond;
    logic                  upd_invalidate;
    logic [CNT_WIDTH-1:0]  branch_count;
    logic [CNT_WIDTH-1:0]  mispredict_count;

    modport master (
        output stall_e, d_valid, d_pc, d_instr, d_pred_taken, d_pred_target,
               e_branch_cond, e_rs1,
        input  mispredict, redirect_pc, upd_valid, upd_pc, upd_taken, upd_target,
               upd_uncond, upd_invalidate, branch_count, mispredict_count
    );

    modport slave (
        input  stall_e, d_valid, d_pc, d_instr, d_pred_taken, d_pred_target,
               e_branch_cond, e_rs1,
        output mispredict, redirect_pc, upd_valid, upd_pc, upd_taken, upd_target,
               upd_uncond, upd_invalidate, branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_resolution_unit.sv
// Resolves branches/jumps in execute against the fetch prediction, redirects on
// mispredict and feeds a registered update packet back to the predictor.
module branch_resolution_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input logic                      clk,
    input logic                      rst,
    branch_resolution_unit_if.slave  bus
);
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic                  taken;
        logic [DATA_WIDTH-1:0] target;
        logic                  uncond;
        logic                  invalidate;
    } upd_t;

    logic                  e_valid;
    logic [DATA_WIDTH-1:0] e_pc;
    logic [DATA_WIDTH-1:0] e_instr;
    logic                  e_pred_taken;
    logic [DATA_WIDTH-1:0] e_pred_target;

    logic                  is_br, is_jal, is_jalr, is_ctrl;
    logic [DATA_WIDTH-1:0] b_imm, j_imm, i_imm;
    logic [DATA_WIDTH-1:0] jalr_sum;
    logic [DATA_WIDTH-1:0] actual_target;
    logic [DATA_WIDTH-1:0] fallthrough;
    logic                  actual_taken;
    logic                  resolve;
    logic                  mispredict;

    upd_t                  upd_q;
    logic                  upd_valid_q;
    logic [CNT_WIDTH-1:0]  branch_cnt_q;
    logic [CNT_WIDTH-1:0]  mispredict_cnt_q;

    assign is_br   = (e_instr[6:0] == OP_BR);
    assign is_jal  = (e_instr[6:0] == OP_JAL);
    assign is_jalr = (e_instr[6:0] == OP_JALR);
    assign is_ctrl = is_br | is_jal | is_jalr;

    assign b_imm = {{(DATA_WIDTH-12){e_instr[31]}}, e_instr[7], e_instr[30:25], e_instr[11:8], 1'b0};
    assign j_imm = {{(DATA_WIDTH-20){e_instr[31]}}, e_instr[19:12], e_instr[20], e_instr[30:21], 1'b0};
    assign i_imm = {{(DATA_WIDTH-12){e_instr[31]}}, e_instr[31:20]};

    assign jalr_sum    = bus.e_rs1 + i_imm;
    assign fallthrough = e_pc + DATA_WIDTH'(4);

    always_comb begin
        actual_target = e_pc + b_imm;
        actual_taken  = 1'b0;
        if (is_br) begin
            actual_taken = bus.e_branch_cond;
        end else if (is_jal) begin
            actual_target = e_pc + j_imm;
            actual_taken  = 1'b1;
        end else if (is_jalr) begin
            actual_target = {jalr_sum[DATA_WIDTH-1:1], 1'b0};
            actual_taken  = 1'b1;
        end
    end

    assign resolve    = e_valid & ~bus.stall_e;
    // A taken/taken pair can still mispredict when the predicted target was stale.
    assign mispredict = resolve & ((actual_taken != e_pred_taken) |
                                   (actual_taken & e_pred_taken & (actual_target != e_pred_target)));

    assign bus.mispredict  = mispredict;
    assign bus.redirect_pc = !mispredict ? '0 : (actual_taken ? actual_target : fallthrough);

    // Execute register; a mispredict means the decode slot holds a wrong-path instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid       <= 1'b0;
            e_pc          <= '0;
            e_instr       <= '0;
            e_pred_taken  <= 1'b0;
            e_pred_target <= '0;
        end else if (!bus.stall_e) begin
            if (mispredict) begin
                e_valid <= 1'b0;
            end else begin
                e_valid       <= bus.d_valid;
                e_pc          <= bus.d_pc;
                e_instr       <= bus.d_instr;
                e_pred_taken  <= bus.d_pred_taken;
                e_pred_target <= bus.d_pred_target;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            upd_valid_q <= 1'b0;
            upd_q       <= '0;
        end else if (resolve && is_ctrl) begin
            upd_valid_q      <= 1'b1;
            upd_q.pc         <= e_pc;
            upd_q.taken      <= actual_taken;
            upd_q.target     <= actual_target;
            upd_q.uncond     <= is_jal | is_jalr;
            upd_q.invalidate <= 1'b0;
        end else if (resolve && e_pred_taken) begin
            upd_valid_q      <= 1'b1;
            upd_q.pc         <= e_pc;
            upd_q.taken      <= 1'b0;
            upd_q.target     <= fallthrough;
            upd_q.uncond     <= 1'b0;
            upd_q.invalidate <= 1'b1;
        end else begin
            upd_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            if (resolve && is_ctrl) branch_cnt_q <= branch_cnt_q + CNT_WIDTH'(1);
            if (mispredict)         mispredict_cnt_q <= mispredict_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign bus.upd_valid        = upd_valid_q;
    assign bus.upd_pc           = upd_q.pc;
    assign bus.upd_taken        = upd_q.taken;
    assign bus.upd_target       = upd_q.target;
    assign bus.upd_uncond       = upd_q.uncond;
    assign bus.upd_invalidate   = upd_q.invalidate;
    assign bus.branch_count     = branch_cnt_q;
    assign bus.mispredict_count = mispredict_cnt_q;
endmodule

// File: tb/tb_branch_resolution_unit.sv
// Directed bench for branch_resolution_unit with a queue-based scoreboard monitor.
module tb_branch_resolution_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
        logic        uncond;
        logic        inv;
    } upd_exp_t;

    upd_exp_t    uq[$];
    logic [31:0] mq[$];

    always #5 clk = ~clk;

    branch_resolution_unit_if #(.DATA_WIDTH(32), .CNT_WIDTH(32)) bus();

    branch_resolution_unit #(.DATA_WIDTH(32), .CNT_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a mispredict or an update.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mispredict === 1'b1) begin
                if (mq.size() == 0) begin
                    chk("unexpected_mispredict", bus.redirect_pc, 32'hDEAD_BEEF);
                end else begin
                    logic [31:0] r;
                    r = mq.pop_front();
                    chk("redirect_pc", bus.redirect_pc, r);
                end
            end else begin
                chk("redirect_idle", bus.redirect_pc, 32'h0);
            end
            if (bus.upd_valid === 1'b1) begin
                if (uq.size() == 0) begin
                    chk("unexpected_upd", bus.upd_pc, 32'hDEAD_BEEF);
                end else begin
                    upd_exp_t u;
                    u = uq.pop_front();
                    chk("upd_pc",         bus.upd_pc,                 u.pc);
                    chk("upd_taken",      {31'b0, bus.upd_taken},     {31'b0, u.taken});
                    chk("upd_target",     bus.upd_target,             u.target);
                    chk("upd_uncond",     {31'b0, bus.upd_uncond},    {31'b0, u.uncond});
                    chk("upd_invalidate", {31'b0, bus.upd_invalidate},{31'b0, u.inv});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                            input logic unc, input logic inv);
        upd_exp_t u;
        u.pc = pc; u.taken = tk; u.target = tgt; u.uncond = unc; u.inv = inv;
        uq.push_back(u);
    endtask

    // Presents an instruction in decode, then leaves it in execute with its operands.
    task automatic issue(input logic [31:0] pc, input logic [31:0] instr, input logic pt,
                         input logic [31:0] ptgt, input logic cond, input logic [31:0] rs1);
        bus.d_valid = 1'b1; bus.d_pc = pc; bus.d_instr = instr;
        bus.d_pred_taken = pt; bus.d_pred_target = ptgt;
        step();
        bus.d_valid = 1'b0; bus.e_branch_cond = cond; bus.e_rs1 = rs1;
    endtask

    task automatic chk_counts(input string tag, input int b, input int m);
        chk({tag, "_branch_count"}, bus.branch_count, b);
        chk({tag, "_mispredict_count"}, bus.mispredict_count, m);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_upd_valid"},  {31'b0, bus.upd_valid}, 32'h0);
        chk({tag, "_upd_pc"},     bus.upd_pc, 32'h0);
        chk({tag, "_upd_taken"},  {31'b0, bus.upd_taken}, 32'h0);
        chk({tag, "_upd_target"}, bus.upd_target, 32'h0);
        chk({tag, "_upd_uncond"}, {31'b0, bus.upd_uncond}, 32'h0);
        chk({tag, "_upd_inv"},    {31'b0, bus.upd_invalidate}, 32'h0);
        chk({tag, "_mispredict"}, {31'b0, bus.mispredict}, 32'h0);
        chk({tag, "_redirect"},   bus.redirect_pc, 32'h0);
        chk_counts(tag, 0, 0);
    endtask

    initial begin
        bus.stall_e = 1'b0; bus.d_valid = 1'b0; bus.d_pc = '0; bus.d_instr = '0;
        bus.d_pred_taken = 1'b0; bus.d_pred_target = '0;
        bus.e_branch_cond = 1'b0; bus.e_rs1 = '0;
        step(); step();
        rst = 1'b0;
        chk_all_zero("reset");

        // beq +8, predicted not-taken, taken
        issue(32'h100, 32'h0000_0463, 1'b0, 32'h0, 1'b1, 32'h0);
        mq.push_back(32'h108); push_upd(32'h100, 1'b1, 32'h108, 1'b0, 1'b0);
        step();
        chk_counts("beq_mp", 1, 1);

        // same beq correctly predicted
        issue(32'h100, 32'h0000_0463, 1'b1, 32'h108, 1'b1, 32'h0);
        push_upd(32'h100, 1'b1, 32'h108, 1'b0, 1'b0);
        step();
        chk_counts("beq_ok", 2, 1);

        // JAL +16 with stale target; wrong-path add predicted taken must be squashed
        issue(32'h200, 32'h0100_006F, 1'b1, 32'h204, 1'b0, 32'h0);
        bus.d_valid = 1'b1; bus.d_pc = 32'h204; bus.d_instr = 32'h0000_0033;
        bus.d_pred_taken = 1'b1; bus.d_pred_target = 32'h900;
        mq.push_back(32'h210); push_upd(32'h200, 1'b1, 32'h210, 1'b1, 1'b0);
        step();
        bus.d_valid = 1'b0;
        step();
        chk_counts("jal", 3, 2);

        // JALR rs1=0x2001 imm=4 -> 0x2004 (bit0 cleared)
        issue(32'h400, 32'h0042_80E7, 1'b0, 32'h0, 1'b0, 32'h2001);
        mq.push_back(32'h2004); push_upd(32'h400, 1'b1, 32'h2004, 1'b1, 1'b0);
        step();
        chk_counts("jalr", 4, 3);

        // add hit a taken prediction -> invalidate
        issue(32'h300, 32'h0000_0033, 1'b1, 32'h400, 1'b0, 32'h0);
        mq.push_back(32'h304); push_upd(32'h300, 1'b0, 32'h304, 1'b0, 1'b1);
        step();
        chk_counts("add_inv", 4, 4);

        // add predicted not-taken: no event
        issue(32'h310, 32'h0000_0033, 1'b0, 32'h0, 1'b1, 32'h0);
        step();
        chk_counts("add_quiet", 4, 4);

        // beq not-taken, correctly predicted: update still carries the branch target
        issue(32'h500, 32'h0000_0463, 1'b0, 32'h0, 1'b0, 32'h0);
        push_upd(32'h500, 1'b0, 32'h508, 1'b0, 1'b0);
        step();
        chk_counts("beq_nt", 5, 4);

        // beq taken, predicted taken to a wrong target
        issue(32'h600, 32'h0000_0463, 1'b1, 32'h700, 1'b1, 32'h0);
        mq.push_back(32'h608); push_upd(32'h600, 1'b1, 32'h608, 1'b0, 1'b0);
        step();
        chk_counts("beq_tgt", 6, 5);

        // wrap: fallthrough of 0xFFFFFFFC is 0, target wraps to 4
        issue(32'hFFFF_FFFC, 32'h0000_0463, 1'b1, 32'h4, 1'b0, 32'h0);
        mq.push_back(32'h0); push_upd(32'hFFFF_FFFC, 1'b0, 32'h4, 1'b0, 1'b0);
        step();
        chk_counts("wrap", 7, 6);

        // stall holds a mispredicting beq, younger decode instr squashed on release
        issue(32'h100, 32'h0000_0463, 1'b0, 32'h0, 1'b1, 32'h0);
        bus.stall_e = 1'b1;
        bus.d_valid = 1'b1; bus.d_pc = 32'h104; bus.d_instr = 32'h0000_0033;
        bus.d_pred_taken = 1'b1; bus.d_pred_target = 32'h900;
        step(); step();
        chk("stall_mispredict", {31'b0, bus.mispredict}, 32'h0);
        chk_counts("stall", 7, 6);
        bus.stall_e = 1'b0;
        mq.push_back(32'h108); push_upd(32'h100, 1'b1, 32'h108, 1'b0, 1'b0);
        step();
        bus.d_valid = 1'b0;
        chk_counts("unstall", 8, 7);

        // reset with a correctly predicted beq in execute: discarded
        issue(32'h100, 32'h0000_0463, 1'b1, 32'h108, 1'b1, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_all_zero("midrst");
        step();
        chk("post_rst_upd_valid", {31'b0, bus.upd_valid}, 32'h0);

        chk("mq_drained", mq.size(), 32'h0);
        chk("uq_drained", uq.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/branch_resolution_unit.md
Name: branch_resolution_unit

Overview:
- Execute-stage consumer of the fetch-side branch prediction.
- Carries each instruction's prediction (taken flag and target) from decode into an execute register.
- Resolves the real control-flow outcome, flags mispredicts with a redirect PC and squashes the wrong-path decode instruction.
- Emits a registered update packet back to the dynamic branch predictor, and keeps branch and mispredict performance counters.

Parameters:
- DATA_WIDTH, 32, width of PC, instruction and target datapaths.
- CNT_WIDTH, 32, width of each performance counter.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- stall_e  input  1  hold execute register; suppresses resolution, updates and counting
- d_valid  input  1  decode stage holds a valid instruction
- d_pc  input  DATA_WIDTH  PC of decode instruction
- d_instr  input  DATA_WIDTH  decode instruction word
- d_pred_taken  input  1  fetch predicted taken
- d_pred_target  input  DATA_WIDTH  fetch predicted target
- e_branch_cond  input  1  ALU compare result for the execute instruction (1 = condition true)
- e_rs1  input  DATA_WIDTH  forwarded rs1 value for JALR
- mispredict  output  1  combinational; redirect fetch and flush decode this cycle
- redirect_pc  output  DATA_WIDTH  correct next PC, valid when mispredict=1
- upd_valid  output  1  registered predictor update strobe
- upd_pc  output  DATA_WIDTH  PC of the resolved instruction
- upd_taken  output  1  actual outcome
- upd_target  output  DATA_WIDTH  actual target
- upd_uncond  output  1  JAL or JALR
- upd_invalidate  output  1  non-control instruction hit a taken prediction; predictor clears the entry
- branch_count  output  CNT_WIDTH  resolved control instructions
- mispredict_count  output  CNT_WIDTH  mispredicts

Behaviour:
- Execute register holds e_valid, e_pc, e_instr, e_pred_taken and e_pred_target.
- Execute register load priority:
  - rst: e_valid=0.
  - stall_e=1: hold.
  - mispredict=1: e_valid=0 (the decode instruction is wrong-path and is dropped even if d_valid=1).
  - Otherwise load the d_* fields, with e_valid=d_valid.
- Opcode classes from e_instr[6:0]:
  - 1100011: BR.
  - 1101111: JAL.
  - 1100111: JALR.
  - Anything else: non-control.
- Immediates, all sign-extended to DATA_WIDTH:
  - B-imm = {instr[31],instr[7],instr[30:25],instr[11:8],0}.
  - J-imm = {instr[31],instr[19:12],instr[20],instr[30:21],0}.
  - I-imm = instr[31:20].
- Actual target:
  - BR: e_pc+B-imm.
  - JAL: e_pc+J-imm.
  - JALR: (e_rs1+I-imm) with bit0 cleared.
  - All adds are modulo 2^DATA_WIDTH.
- actual_taken = e_branch_cond for BR, 1 for JAL/JALR, 0 for non-control.
- Fallthrough = e_pc+4, wrapping.
- resolve = e_valid & ~stall_e.
- mispredict = resolve & ((actual_taken != e_pred_taken) | (actual_taken & e_pred_taken & actual_target != e_pred_target)).
- redirect_pc = actual_taken ? actual_target : e_pc+4. It is 0 when mispredict=0.
- Update packet, registered so it appears 1 cycle after resolve:
  - Control instruction resolved: upd_valid=1, upd_invalidate=0, with the remaining upd_* fields loaded from the resolution.
  - Non-control instruction with e_pred_taken=1: upd_valid=1, upd_invalidate=1, upd_taken=0, upd_target=e_pc+4, upd_uncond=0.
  - Otherwise: upd_valid=0 and the upd_* data fields hold their previous values.
- Counters:
  - branch_count increments on resolve of a control instruction.
  - mispredict_count increments on each mispredict, including invalidate cases.
  - Both wrap modulo 2^CNT_WIDTH.
- Reset values: e_valid=0, upd_*=0, counters=0. mispredict and redirect_pc read 0 while e_valid=0.
- rst mid-operation: an in-flight execute instruction is discarded, with no update and no count.
- Back-to-back mispredicts are impossible because a mispredict always leaves the next execute slot empty.

Test Plan:
- beq with e_pc=0x100, instr 0x00000463, e_branch_cond=1, predicted not-taken -> mispredict=1, redirect_pc=0x108; next cycle upd_valid=1, upd_taken=1, upd_target=0x108, upd_uncond=0; mispredict_count=1, branch_count=1.
- Same beq predicted taken to 0x108 with cond=1 -> mispredict=0; next cycle upd_taken=1; only branch_count increments.
- JAL 0x0100006F at 0x200, predicted taken to 0x204 -> mispredict=1 (target mismatch), redirect_pc=0x210, upd_uncond=1; the d_valid instruction the same cycle is squashed, so e_valid=0 next cycle.
- JALR 0x004280E7 with e_rs1=0x2001, predicted not-taken -> redirect_pc=0x2004, upd_target=0x2004.
- Add instruction at 0x300 with pred_taken=1 -> mispredict=1, redirect_pc=0x304, upd_invalidate=1; branch_count unchanged.
- stall_e=1 with a mispredicting branch in execute -> mispredict=0, no update, counters hold. Deassert stall_e -> mispredict fires that cycle. Then assert rst -> all outputs 0 on the following cycle.
